// File: rtl/lab4_pkg.sv
// rtl/lab4_pkg.sv - shared FSM state type and seven-segment table for seq_divider
// Contents:
//   state_t    : divider FSM states
//   abs8       : 8-bit two's complement magnitude (abs8(8'h80) = 8'h80)
//   seg_table  : hex nibble -> active-low {dp,g,f,e,d,c,b,a}, dp always off
package lab4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIVIDE = 3'd2,
    FIXUP  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [7:0] abs8(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

  function automatic logic [7:0] seg_table(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/hex_driver.sv
// rtl/hex_driver.sv - four-digit multiplexed seven-segment scanner
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   nib3..nib0         : digits shown on grid bits 3..0
//   hex_segA [7:0]     : active-low segments {dp,g,f,e,d,c,b,a}
//   hex_gridA [3:0]    : active-low digit enables, one low at a time
module hex_driver
  import lab4_pkg::*;
#(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nib3,
  input  logic [3:0] nib2,
  input  logic [3:0] nib1,
  input  logic [3:0] nib0,
  output logic [7:0] hex_segA,
  output logic [3:0] hex_gridA
);

  // Top two bits select the digit, so each digit is held 2^REFRESH_BITS clocks.
  logic [REFRESH_BITS+1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;

  assign sel = refresh[REFRESH_BITS+1 -: 2];

  always_ff @(posedge clk) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + 1'b1;
  end

  always_comb begin
    digit     = nib3;
    hex_gridA = 4'b0111;
    case (sel)
      2'd0: begin digit = nib3; hex_gridA = 4'b0111; end
      2'd1: begin digit = nib2; hex_gridA = 4'b1011; end
      2'd2: begin digit = nib1; hex_gridA = 4'b1101; end
      default: begin digit = nib0; hex_gridA = 4'b1110; end
    endcase
    hex_segA = seg_table(digit);
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 8-bit signed sequential restoring divider with hex display
// Ports:
//   clk            : clock
//   reset_load_clr : synchronous active-high reset; captures sw_i as divisor
//   run_i          : start request (rising edge, IDLE only)
//   sw_i [7:0]     : divisor at reset, dividend at run
//   Aval [7:0]     : remainder (sign follows dividend)
//   Bval [7:0]     : quotient (truncated toward zero)
//   sign_LED       : Bval[7]
//   err_o          : last operation divided by zero
//   hex_segA/gridA : multiplexed display of {Aval, Bval}
module seq_divider
  import lab4_pkg::*;
#(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       reset_load_clr,
  input  logic       run_i,
  input  logic [7:0] sw_i,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       sign_LED,
  output logic       err_o,
  output logic [7:0] hex_segA,
  output logic [3:0] hex_gridA
);

  state_t     state;
  logic       run_prev;
  logic [7:0] divisor;
  logic [7:0] dividend;
  logic [7:0] abs_div;
  logic [7:0] rem;
  logic [7:0] quo;
  logic [2:0] count;

  // One restoring step: shift {rem,quo} left, subtract if the divisor fits.
  // Nine bits because a shifted remainder can exceed 8-bit range for |divisor| = 0x80.
  logic [8:0] shifted;
  logic       fits;
  logic [8:0] step_rem;

  assign shifted  = {rem, quo[7]};
  assign fits     = shifted >= {1'b0, abs_div};
  assign step_rem = fits ? (shifted - {1'b0, abs_div}) : shifted;
  assign sign_LED = Bval[7];

  always_ff @(posedge clk) begin
    if (reset_load_clr) begin
      state    <= IDLE;
      Aval     <= 8'h00;
      Bval     <= 8'h00;
      err_o    <= 1'b0;
      divisor  <= sw_i;
      dividend <= 8'h00;
      abs_div  <= 8'h00;
      rem      <= 8'h00;
      quo      <= 8'h00;
      count    <= 3'd0;
      run_prev <= 1'b1;  // a button already held at reset is not an edge
    end else begin
      run_prev <= run_i;
      case (state)
        IDLE: begin
          if (run_i && !run_prev) state <= LOAD;
        end
        LOAD: begin
          dividend <= sw_i;
          abs_div  <= abs8(divisor);
          quo      <= abs8(sw_i);
          rem      <= 8'h00;
          count    <= 3'd0;
          if (divisor == 8'h00) begin
            state <= FIXUP;
          end else begin
            err_o <= 1'b0;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem   <= step_rem[7:0];
          quo   <= {quo[6:0], fits};
          count <= count + 3'd1;
          if (count == 3'd7) state <= FIXUP;
        end
        FIXUP: begin
          if (divisor == 8'h00) begin
            Aval  <= dividend;
            Bval  <= 8'hFF;
            err_o <= 1'b1;
          end else begin
            Bval <= (dividend[7] ^ divisor[7]) ? (~quo + 8'd1) : quo;
            Aval <= dividend[7] ? (~rem + 8'd1) : rem;
          end
          state <= DONE;
        end
        DONE: begin
          if (!run_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hex_driver #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_hex (
    .clk      (clk),
    .reset    (reset_load_clr),
    .nib3     (Aval[7:4]),
    .nib2     (Aval[3:0]),
    .nib1     (Bval[7:4]),
    .nib0     (Bval[3:0]),
    .hex_segA (hex_segA),
    .hex_gridA(hex_gridA)
  );

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 16, giving log2 of the number of clocks each display digit is held.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_load_clr, input, 1 bit: reset, synchronous and active-high; also loads the divisor.
REQ-004 SHALL have port run_i, input, 1 bit: start request, level from pushbutton.
REQ-005 SHALL have port sw_i, input, 8 bits: divisor source at reset, dividend source at run.
REQ-006 SHALL have port Aval, output, 8 bits: remainder register, two's complement.
REQ-007 SHALL have port Bval, output, 8 bits: quotient register, two's complement.
REQ-008 SHALL have port sign_LED, output, 1 bit: equals Bval[7].
REQ-009 SHALL have port err_o, output, 1 bit: divide-by-zero flag for the last operation.
REQ-010 SHALL have port hex_segA, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1.
REQ-011 SHALL have port hex_gridA, output, 4 bits: active-low digit enables, exactly one 0 at a time.

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD, DIVIDE, FIXUP and DONE.
REQ-013 SHALL start on run_i rising edge (registered previous value 0, current 1) in IDLE only; edges in other states are ignored.
REQ-014 SHALL, in LOAD (1 cycle), capture dividend = sw_i, take |dividend| and |divisor| as 8-bit unsigned (|-128| = 0x80), clear the partial remainder, and clear the counter.
REQ-015 SHALL, in DIVIDE (exactly 8 cycles, 3-bit counter), perform one unsigned restoring step per cycle: shift {rem,quo} left 1; if rem >= |divisor|, subtract and set quo[0]=1.
REQ-016 SHALL, in FIXUP (1 cycle), negate the quotient if the operand signs differ, negate the remainder if the dividend is negative, then load Aval/Bval (truncation toward zero).
REQ-017 SHALL make results visible in DONE, 10 clocks after the cycle in which the run edge is sampled.
REQ-018 SHALL leave DONE for IDLE only after run_i is sampled 0; holding run_i high never starts a second divide.
REQ-019 SHALL, with divisor 0, skip DIVIDE: LOAD -> FIXUP, Aval = dividend, Bval = 0xFF, err_o = 1; err_o clears at the next LOAD with a non-zero divisor.
REQ-020 SHALL keep Aval/Bval unchanged during LOAD/DIVIDE (internal working registers only).
REQ-021 SHALL result in Bval = 0x80, Aval = 0x00 for -128 / -1 (wrap, no error).
REQ-022 SHALL scan the display digits {Aval[7:4], Aval[3:0], Bval[7:4], Bval[3:0]} on grid bits 3..0, advancing one digit every 2^REFRESH_BITS clocks, wrapping 0 -> 3.

Reset
REQ-023 SHALL, while reset_load_clr = 1 on a clock edge: go to IDLE, Aval = 0x00, Bval = 0x00, err_o = 0, divisor register = sw_i, counter and refresh counter = 0, run edge register = 1.
REQ-024 SHALL, on reset during any state including DIVIDE, abort the operation with no partial result reaching Aval/Bval.
REQ-025 SHALL, in the first cycle after reset, drive hex_gridA = 4'b0111 and hex_segA = 8'hC0 (digit 0).

Structure
REQ-026 SHALL place the FSM state enum and the 16-entry seven-segment table in shared package lab4_pkg.
REQ-027 SHALL place display scanning in one sub-module, hex_driver (clk, reset, four nibbles in, hex_segA/hex_gridA out); the division datapath stays in seq_divider.

Verification
REQ-028 SHALL cover: reset with sw_i=0x07, run with sw_i=0x64 -> 10 clocks later Bval=0x0E, Aval=0x02, sign_LED=0, err_o=0.
REQ-029 SHALL cover: divisor 0x07, dividend 0x9C (-100) -> Bval=0xF2, Aval=0xFE, sign_LED=1.
REQ-030 SHALL cover: divisor 0xFF, dividend 0x80 -> Bval=0x80, Aval=0x00, err_o=0.
REQ-031 SHALL cover: divisor 0x00, dividend 0x2A -> Bval=0xFF, Aval=0x2A, err_o=1; then a valid divide clears err_o.
REQ-032 SHALL cover: run_i held high 40 clocks -> exactly one operation; assert reset 4 clocks into DIVIDE -> Aval=Bval=0, state IDLE.
REQ-033 SHALL cover: REFRESH_BITS=2, Aval=0x12, Bval=0xAB -> hex_gridA cycles 0111,1011,1101,1110 every 4 clocks with segA C0-table codes F9,A4,88,83.
